// File: rtl/bram_march_test.sv
// March C- built-in self-test engine for a dual-port BRAM with a
// one-cycle registered read port.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_run             level start/enable
//   o_running         high while a march element is in progress
//   o_done, o_passed  end-of-test status
//   o_wr_en/o_waddr/o_wdata   BRAM write port
//   o_rd_en/o_raddr/i_rdata   BRAM read port (data one cycle after enable)
//   o_fail_addr/exp/got       first-mismatch capture
//   o_fail_count              saturating mismatch count
module bram_march_test #(
    parameter int unsigned        DATA_SZ      = 16,
    parameter int unsigned        ADDR_SZ      = 8,
    parameter int unsigned        DEPTH        = 256,
    parameter logic [DATA_SZ-1:0] PATTERN      = '0,
    parameter bit                 STOP_ON_FAIL = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    output logic               o_running,
    output logic               o_done,
    output logic               o_passed,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata,
    output logic [ADDR_SZ-1:0] o_fail_addr,
    output logic [DATA_SZ-1:0] o_fail_exp,
    output logic [DATA_SZ-1:0] o_fail_got,
    output logic [15:0]        o_fail_count
);

    // Element order matters: the next element is always state + 1,
    // and E5 + 1 lands on DONE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_E0   = 3'd1,
        S_E1   = 3'd2,
        S_E2   = 3'd3,
        S_E3   = 3'd4,
        S_E4   = 3'd5,
        S_E5   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [DATA_SZ-1:0] B0   = PATTERN;
    localparam logic [DATA_SZ-1:0] B1   = ~PATTERN;
    localparam logic [ADDR_SZ-1:0] LAST = ADDR_SZ'(DEPTH - 1);

    state_t             state_q, state_d, next_elem;
    logic               ck_q, ck_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [ADDR_SZ-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_SZ-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_SZ-1:0] fail_got_q, fail_got_d;
    logic [15:0]        count_q, count_d;

    logic               in_rw;
    logic               is_down;
    logic               elem_end;
    logic               mismatch;
    logic               start;
    logic               wr_e0;
    logic               wr_ck;
    logic [DATA_SZ-1:0] exp_data;
    logic [DATA_SZ-1:0] ck_wdata;

    always_comb begin
        in_rw     = (state_q == S_E1) || (state_q == S_E2) ||
                    (state_q == S_E3) || (state_q == S_E4) ||
                    (state_q == S_E5);
        is_down   = (state_q == S_E3) || (state_q == S_E4);
        elem_end  = is_down ? (addr_q == '0) : (addr_q == LAST);
        next_elem = state_t'(state_q + 3'd1);
        exp_data  = ((state_q == S_E2) || (state_q == S_E4)) ? B1 : B0;
        ck_wdata  = ((state_q == S_E1) || (state_q == S_E3)) ? B1 : B0;
        mismatch  = in_rw && ck_q && (i_rdata != exp_data);
        start     = (state_q == S_IDLE) && i_run;
    end

    // Sequencer: E0 is one cycle per address, E1..E5 alternate RD/CK.
    always_comb begin
        state_d = state_q;
        ck_d    = ck_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d = S_E0;
                    addr_d  = '0;
                    ck_d    = 1'b0;
                end
            end
            S_E0: begin
                if (elem_end) begin
                    state_d = S_E1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_SZ'(1);
                end
            end
            S_E1, S_E2, S_E3, S_E4, S_E5: begin
                if (!ck_q) begin
                    ck_d = 1'b1;
                end else begin
                    ck_d = 1'b0;
                    if (mismatch && STOP_ON_FAIL) begin
                        state_d = S_DONE;
                    end else if (elem_end) begin
                        state_d = next_elem;
                        // Down elements reload at the top address.
                        addr_d  = ((next_elem == S_E3) ||
                                   (next_elem == S_E4)) ? LAST : '0;
                    end else if (is_down) begin
                        addr_d = addr_q - ADDR_SZ'(1);
                    end else begin
                        addr_d = addr_q + ADDR_SZ'(1);
                    end
                end
            end
            S_DONE: begin
                if (!i_run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        count_d     = count_q;
        if (start) begin
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
            count_d     = '0;
        end else if (mismatch) begin
            if (count_q == '0) begin
                fail_addr_d = addr_q;
                fail_exp_d  = exp_data;
                fail_got_d  = i_rdata;
            end
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ck_q        <= 1'b0;
            addr_q      <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ck_q        <= ck_d;
            addr_q      <= addr_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            count_q     <= count_d;
        end
    end

    // Port decode from registered state only; IDLE/DONE drive zeros.
    always_comb begin
        wr_e0     = (state_q == S_E0);
        wr_ck     = in_rw && ck_q && (state_q != S_E5);
        o_running = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done    = (state_q == S_DONE);
        o_passed  = o_done && (count_q == '0);
        o_wr_en   = wr_e0 || wr_ck;
        o_waddr   = o_wr_en ? addr_q : '0;
        o_wdata   = wr_e0 ? B0 : (wr_ck ? ck_wdata : '0);
        o_rd_en   = in_rw && !ck_q;
        o_raddr   = o_rd_en ? addr_q : '0;
    end

    assign o_fail_addr  = fail_addr_q;
    assign o_fail_exp   = fail_exp_q;
    assign o_fail_got   = fail_got_q;
    assign o_fail_count = count_q;

endmodule

// File: tb/tb_bram_march_test.sv
// Bench for bram_march_test: three DEPTH=4 instances beside BRAM models
// with injectable stuck-at faults, checked against a march reference.
module tb_bram_march_test;

    localparam int NDUT = 3;
    localparam int DP   = 4;

    logic clk = 1'b0;
    logic rst;
    logic run;

    logic        running[NDUT];
    logic        done[NDUT];
    logic        passed[NDUT];
    logic        wr_en[NDUT];
    logic        rd_en[NDUT];
    logic [7:0]  waddr[NDUT];
    logic [7:0]  raddr[NDUT];
    logic [7:0]  fail_addr[NDUT];
    logic [15:0] wdata[NDUT];
    logic [15:0] rdata[NDUT];
    logic [15:0] fail_exp[NDUT];
    logic [15:0] fail_got[NDUT];
    logic [15:0] fail_count[NDUT];

    always #5 clk = ~clk;

    bram_march_test #(
        .DATA_SZ(16), .ADDR_SZ(8), .DEPTH(DP),
        .PATTERN(16'h0000), .STOP_ON_FAIL(1'b1)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_run(run),
        .o_running(running[0]), .o_done(done[0]),
        .o_passed(passed[0]), .o_wr_en(wr_en[0]),
        .o_waddr(waddr[0]), .o_wdata(wdata[0]),
        .o_rd_en(rd_en[0]), .o_raddr(raddr[0]),
        .i_rdata(rdata[0]), .o_fail_addr(fail_addr[0]),
        .o_fail_exp(fail_exp[0]), .o_fail_got(fail_got[0]),
        .o_fail_count(fail_count[0])
    );

    bram_march_test #(
        .DATA_SZ(16), .ADDR_SZ(8), .DEPTH(DP),
        .PATTERN(16'h0000), .STOP_ON_FAIL(1'b0)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_run(run),
        .o_running(running[1]), .o_done(done[1]),
        .o_passed(passed[1]), .o_wr_en(wr_en[1]),
        .o_waddr(waddr[1]), .o_wdata(wdata[1]),
        .o_rd_en(rd_en[1]), .o_raddr(raddr[1]),
        .i_rdata(rdata[1]), .o_fail_addr(fail_addr[1]),
        .o_fail_exp(fail_exp[1]), .o_fail_got(fail_got[1]),
        .o_fail_count(fail_count[1])
    );

    bram_march_test #(
        .DATA_SZ(16), .ADDR_SZ(8), .DEPTH(DP),
        .PATTERN(16'h5A5A), .STOP_ON_FAIL(1'b1)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_run(run),
        .o_running(running[2]), .o_done(done[2]),
        .o_passed(passed[2]), .o_wr_en(wr_en[2]),
        .o_waddr(waddr[2]), .o_wdata(wdata[2]),
        .o_rd_en(rd_en[2]), .o_raddr(raddr[2]),
        .i_rdata(rdata[2]), .o_fail_addr(fail_addr[2]),
        .o_fail_exp(fail_exp[2]), .o_fail_got(fail_got[2]),
        .o_fail_count(fail_count[2])
    );

    // Fault injection: masked bits of one address read back as fval.
    bit          fen[NDUT];
    int          faddr[NDUT];
    logic [15:0] fmask[NDUT];
    logic [15:0] fval[NDUT];
    logic [15:0] mem[NDUT][DP];
    logic [25:0] wq[$];
    logic [23:0] m_wq[$];

    function automatic logic [15:0] flt(int g, int a, logic [15:0] v);
        if (fen[g] && a == faddr[g])
            return (v & ~fmask[g]) | (fval[g] & fmask[g]);
        return v;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rd_en[g] === 1'b1)
                rdata[g] <= flt(g, int'(raddr[g]), mem[g][raddr[g][1:0]]);
            if (wr_en[g] === 1'b1)
                mem[g][waddr[g][1:0]] <= wdata[g];
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++)
            if (wr_en[g] === 1'b1)
                wq.push_back({2'(g), waddr[g], wdata[g]});
    end

    function automatic logic [15:0] pat_of(int g);
        return (g == 2) ? 16'h5A5A : 16'h0000;
    endfunction

    function automatic bit stop_of(int g);
        return g != 1;
    endfunction

    // Reference: walk the March C- element list over an array memory.
    int          e_cyc, e_cnt;
    logic [7:0]  e_fa;
    logic [15:0] e_fe, e_fg;

    task automatic model(input int g);
        logic [15:0] m[DP];
        logic [15:0] pat, ex, got;
        int a;
        pat = pat_of(g);
        m_wq.delete();
        e_cyc = 0; e_cnt = 0; e_fa = 0; e_fe = 0; e_fg = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DP; k++) begin
                a = (e == 3 || e == 4) ? DP - 1 - k : k;
                if (e == 0) begin
                    m[a] = pat;
                    m_wq.push_back({8'(a), pat});
                    e_cyc++;
                end else begin
                    ex  = (e % 2 == 1) ? pat : ~pat;
                    got = flt(g, a, m[a]);
                    e_cyc += 2;
                    if (e != 5) begin
                        m[a] = (e % 2 == 1) ? ~pat : pat;
                        m_wq.push_back({8'(a), m[a]});
                    end
                    if (got !== ex) begin
                        if (e_cnt == 0) begin
                            e_fa = 8'(a); e_fe = ex; e_fg = got;
                        end
                        e_cnt++;
                        if (stop_of(g)) return;
                    end
                end
            end
        end
    endtask

    function automatic int trace_diff(int g);
        int j = 0;
        foreach (wq[i]) begin
            if (int'(wq[i][25:24]) == g) begin
                if (j >= m_wq.size() || wq[i][23:0] !== m_wq[j]) return j;
                j++;
            end
        end
        if (j != m_wq.size()) return j;
        return -1;
    endfunction

    function automatic logic [23:0] nth_wr(int g, int n);
        int j = 0;
        foreach (wq[i]) begin
            if (int'(wq[i][25:24]) == g) begin
                if (j == n) return wq[i][23:0];
                j++;
            end
        end
        return 'x;
    endfunction

    int          npass = 0;
    int          ntot  = 0;
    int          cyc[NDUT];
    bit          seen[NDUT];
    bit          tmo;
    logic        sn_passed[NDUT];
    logic [15:0] sn_cnt[NDUT], sn_fe[NDUT], sn_fg[NDUT];
    logic [7:0]  sn_fa[NDUT];
    logic [15:0] st_cnt[NDUT];
    logic [7:0]  st_fa[NDUT];

    // Called at a negedge; raises i_run, snapshots each DUT on DONE,
    // optionally drops i_run mid-run, then returns all DUTs to IDLE.
    task automatic do_run(input int drop_at);
        wq.delete();
        tmo = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            cyc[g] = 0; seen[g] = 1'b0;
        end
        run = 1'b1;
        for (int t = 0; t < 600; t++) begin
            if (seen[0] && seen[1] && seen[2]) break;
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (!seen[g]) begin
                    if (running[g] === 1'b1) begin
                        if (cyc[g] == 0) begin
                            st_cnt[g] = fail_count[g];
                            st_fa[g]  = fail_addr[g];
                        end
                        cyc[g]++;
                    end
                    if (done[g] === 1'b1) begin
                        seen[g]      = 1'b1;
                        sn_passed[g] = passed[g];
                        sn_cnt[g]    = fail_count[g];
                        sn_fa[g]     = fail_addr[g];
                        sn_fe[g]     = fail_exp[g];
                        sn_fg[g]     = fail_got[g];
                    end
                end
            end
            if (t == drop_at) run = 1'b0;
        end
        if (!(seen[0] && seen[1] && seen[2])) tmo = 1'b1;
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [92:0] v;
        rst = 1'b1; run = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            v = {running[g], done[g], passed[g], wr_en[g], rd_en[g],
                 waddr[g], raddr[g], wdata[g], fail_addr[g],
                 fail_exp[g], fail_got[g], fail_count[g]};
            ntot++;
            if (v !== '0)
                $display("FAIL reset_outs dut%0d: got %h want 0", g, v);
            else npass++;
        end
        run = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pass();
        for (int g = 0; g < NDUT; g++) fen[g] = 1'b0;
        do_run(-1);
        ntot++;
        if (tmo !== 1'b0) $display("FAIL pass_timeout: got 1 want 0");
        else npass++;
        for (int g = 0; g < NDUT; g++) begin
            model(g);
            ntot++;
            if (cyc[g] != 11 * DP)
                $display("FAIL pass_cycles dut%0d: got %0d want %0d",
                         g, cyc[g], 11 * DP);
            else npass++;
            ntot++;
            if ({seen[g], sn_passed[g], sn_cnt[g]} !== {2'b11, 16'h0})
                $display("FAIL pass_status dut%0d: got %b%b/%0d want 11/0",
                         g, seen[g], sn_passed[g], sn_cnt[g]);
            else npass++;
            ntot++;
            if (nth_wr(g, 0) !== {8'h00, pat_of(g)})
                $display("FAIL first_write dut%0d: got %h want %h",
                         g, nth_wr(g, 0), {8'h00, pat_of(g)});
            else npass++;
            ntot++;
            if (nth_wr(g, DP) !== {8'h00, ~pat_of(g)})
                $display("FAIL e1_first_write dut%0d: got %h want %h",
                         g, nth_wr(g, DP), {8'h00, ~pat_of(g)});
            else npass++;
            ntot++;
            if (trace_diff(g) != -1)
                $display("FAIL pass_wtrace dut%0d: got diff@%0d want none",
                         g, trace_diff(g));
            else npass++;
            ntot++;
            if ({running[g], done[g]} !== 2'b00)
                $display("FAIL pass_idle dut%0d: got %b%b want 00",
                         g, running[g], done[g]);
            else npass++;
        end
    endtask

    // Bit 3 of address 2 stuck at 1, then a clean rerun.
    task automatic test_fail_hold();
        int          w_cyc[NDUT];
        int          w_cnt[NDUT];
        logic [15:0] w_fe[NDUT];
        logic [15:0] w_fg[NDUT];
        w_cyc = '{10, 44, 18};
        w_cnt = '{1, 3, 1};
        w_fe  = '{16'h0000, 16'h0000, 16'hA5A5};
        w_fg  = '{16'h0008, 16'h0008, 16'hA5AD};
        for (int g = 0; g < NDUT; g++) begin
            fen[g] = 1'b1; faddr[g] = 2;
            fmask[g] = 16'h0008; fval[g] = 16'h0008;
        end
        do_run(-1);
        ntot++;
        if (tmo !== 1'b0) $display("FAIL stuck_timeout: got 1 want 0");
        else npass++;
        for (int g = 0; g < NDUT; g++) begin
            ntot++;
            if (cyc[g] != w_cyc[g])
                $display("FAIL stuck_cycles dut%0d: got %0d want %0d",
                         g, cyc[g], w_cyc[g]);
            else npass++;
            ntot++;
            if ({sn_passed[g], sn_cnt[g], sn_fa[g], sn_fe[g], sn_fg[g]}
                !== {1'b0, 16'(w_cnt[g]), 8'd2, w_fe[g], w_fg[g]})
                $display("FAIL stuck_capture dut%0d: got p%b n%0d a%0d %h/%h want p0 n%0d a2 %h/%h",
                         g, sn_passed[g], sn_cnt[g], sn_fa[g], sn_fe[g],
                         sn_fg[g], w_cnt[g], w_fe[g], w_fg[g]);
            else npass++;
            ntot++;
            if ({done[g], fail_count[g], fail_addr[g], fail_got[g]}
                !== {1'b0, 16'(w_cnt[g]), 8'd2, w_fg[g]})
                $display("FAIL idle_hold dut%0d: got d%b n%0d a%0d %h want d0 n%0d a2 %h",
                         g, done[g], fail_count[g], fail_addr[g],
                         fail_got[g], w_cnt[g], w_fg[g]);
            else npass++;
        end
        for (int g = 0; g < NDUT; g++) fen[g] = 1'b0;
        do_run(-1);
        for (int g = 0; g < NDUT; g++) begin
            ntot++;
            if ({st_cnt[g], st_fa[g]} !== 24'h0)
                $display("FAIL start_clear dut%0d: got n%0d a%0d want 0/0",
                         g, st_cnt[g], st_fa[g]);
            else npass++;
            ntot++;
            if ({seen[g], sn_passed[g], cyc[g] == 11 * DP} !== 3'b111)
                $display("FAIL rerun_pass dut%0d: got p%b cyc %0d want p1 cyc %0d",
                         g, sn_passed[g], cyc[g], 11 * DP);
            else npass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [92:0] v;
        for (int g = 0; g < NDUT; g++) fen[g] = 1'b0;
        run = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            v = {running[g], done[g], passed[g], wr_en[g], rd_en[g],
                 waddr[g], raddr[g], wdata[g], fail_addr[g],
                 fail_exp[g], fail_got[g], fail_count[g]};
            ntot++;
            if (v !== '0)
                $display("FAIL midreset_outs dut%0d: got %h want 0", g, v);
            else npass++;
        end
        rst = 1'b0;
        do_run(-1);
        for (int g = 0; g < NDUT; g++) begin
            model(g);
            ntot++;
            if ({seen[g], sn_passed[g], cyc[g] == e_cyc} !== 3'b111)
                $display("FAIL restart dut%0d: got p%b cyc %0d want p1 cyc %0d",
                         g, sn_passed[g], cyc[g], e_cyc);
            else npass++;
            ntot++;
            if (trace_diff(g) != -1)
                $display("FAIL restart_wtrace dut%0d: got diff@%0d want none",
                         g, trace_diff(g));
            else npass++;
        end
    endtask

    task automatic test_random();
        int drop;
        for (int it = 0; it < 24; it++) begin
            for (int g = 0; g < NDUT; g++) begin
                fen[g]   = ($urandom_range(0, 3) != 0);
                faddr[g] = $urandom_range(0, DP - 1);
                fmask[g] = ($urandom_range(0, 1) != 0)
                         ? 16'(1 << $urandom_range(0, 15))
                         : 16'($urandom);
                fval[g]  = 16'($urandom);
            end
            drop = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 8) : -1;
            do_run(drop);
            ntot++;
            if (tmo !== 1'b0)
                $display("FAIL rand_timeout it%0d: got 1 want 0", it);
            else npass++;
            for (int g = 0; g < NDUT; g++) begin
                model(g);
                ntot++;
                if (cyc[g] != e_cyc)
                    $display("FAIL rand_cycles it%0d dut%0d: got %0d want %0d",
                             it, g, cyc[g], e_cyc);
                else npass++;
                ntot++;
                if ({sn_passed[g], sn_cnt[g]} !== {e_cnt == 0, 16'(e_cnt)})
                    $display("FAIL rand_count it%0d dut%0d: got p%b n%0d want p%b n%0d",
                             it, g, sn_passed[g], sn_cnt[g], e_cnt == 0, e_cnt);
                else npass++;
                ntot++;
                if ({sn_fa[g], sn_fe[g], sn_fg[g]} !== {e_fa, e_fe, e_fg})
                    $display("FAIL rand_capture it%0d dut%0d: got %0d %h/%h want %0d %h/%h",
                             it, g, sn_fa[g], sn_fe[g], sn_fg[g],
                             e_fa, e_fe, e_fg);
                else npass++;
                ntot++;
                if (trace_diff(g) != -1)
                    $display("FAIL rand_wtrace it%0d dut%0d: got diff@%0d want none",
                             it, g, trace_diff(g));
                else npass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            fen[g] = 1'b0; faddr[g] = 0;
            fmask[g] = '0; fval[g] = '0;
        end
        @(negedge clk);
        test_reset();
        test_pass();
        test_fail_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/bram_march_test.md
Name: bram_march_test

Overview:
- Parametrised built-in self-test engine for a dual-port block RAM (separate write and read ports, 1-cycle registered read).
- Runs a March C- sequence over a configurable address range and data background.
- Reports pass/fail plus a first-failure capture (address, expected, actual) and a saturating fail count.
- Sits beside a BRAM instance in test fixtures and on-board bring-up designs; drives the BRAM ports directly.

Parameters:
- DATA_SZ, 16, BRAM data width in bits.
- ADDR_SZ, 8, BRAM address width in bits.
- DEPTH, 256, number of words tested (addresses 0..DEPTH-1); 2 <= DEPTH <= 2**ADDR_SZ.
- PATTERN, 0 (DATA_SZ bits), background "0" value; background "1" is ~PATTERN.
- STOP_ON_FAIL, 1, 1 = go to DONE on the first mismatch; 0 = run to completion and count all mismatches.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_run  in  1  level: start/enable the test
- o_running  out  1  high while a march element is in progress
- o_done  out  1  high in DONE
- o_passed  out  1  high in DONE when no mismatch was recorded
- o_wr_en  out  1  BRAM write enable
- o_waddr  out  ADDR_SZ  BRAM write address
- o_wdata  out  DATA_SZ  BRAM write data
- o_rd_en  out  1  BRAM read enable
- o_raddr  out  ADDR_SZ  BRAM read address
- i_rdata  in  DATA_SZ  BRAM read data, valid the cycle after o_rd_en
- o_fail_addr  out  ADDR_SZ  address of the first mismatch
- o_fail_exp  out  DATA_SZ  expected data at the first mismatch
- o_fail_got  out  DATA_SZ  actual data at the first mismatch
- o_fail_count  out  16  mismatch count, saturating at 16'hFFFF

Behaviour:
- States: IDLE, then march elements E0..E5, then DONE. Let B0 = PATTERN and B1 = ~PATTERN.
  - E0: up, w B0
  - E1: up, r B0 then w B1
  - E2: up, r B1 then w B0
  - E3: down, r B0 then w B1
  - E4: down, r B1 then w B0
  - E5: up, r B0
- Up elements start at address 0 and end at DEPTH-1. Down elements start at DEPTH-1 and end at 0. The address counter reloads at each element boundary; no wrap outside 0..DEPTH-1.
- E0 takes 1 cycle per address: o_wr_en=1, o_waddr=A, o_wdata=B0.
- E1..E5 take 2 cycles per address:
  - RD phase: o_rd_en=1, o_raddr=A.
  - CK phase: compare i_rdata against the expected value. In E1..E4 the same CK cycle asserts o_wr_en=1, o_waddr=A, o_wdata = complement background. E5 issues no write.
- o_running is high for exactly 11*DEPTH cycles on a passing run.
- Memory-port outputs are decoded from registered state. In IDLE and DONE: o_wr_en=0, o_rd_en=0, addresses and data 0.
- Start: i_run sampled high in IDLE -> next cycle is E0 at address 0, and o_running=1. Fail registers and count are cleared on this transition.
- Mismatch in a CK cycle (i_rdata != expected):
  - If the count is 0 before this mismatch, latch o_fail_addr/exp/got.
  - Increment o_fail_count (saturating).
  - STOP_ON_FAIL=1: next state is DONE; the write for that CK cycle is still issued.
- Normal completion: after the last E5 CK cycle, go to DONE.
- DONE: o_done=1, o_running=0, o_passed = (o_fail_count==0). Fail registers hold.
- Leaving DONE: stay while i_run=1. i_run=0 in DONE -> IDLE next cycle, with fail registers held until the next start.
- i_run dropping mid-run is ignored; the test completes.
- Reset (any state, including mid-element):
  - Next cycle is IDLE.
  - All outputs 0: o_running, o_done, o_passed, fail regs, count, and memory enables.
  - No partial write or read is issued in the cycle after the reset edge.
- Reset has priority over i_run in the same cycle.

Test Plan:
- Ideal 4-word model, DEPTH=4, DATA_SZ=16, PATTERN=0, i_run held high -> o_running high for exactly 44 cycles. First write is addr 0 data 16'h0000; E1's first write is addr 0 data 16'hFFFF. Then o_done=1, o_passed=1, o_fail_count=0.
- Same setup with PATTERN=16'h5A5A -> E0 writes 16'h5A5A to addrs 0..3; E1 writes 16'hA5A5; pass after 44 running cycles.
- Model with bit 3 of addr 2 stuck at 1, STOP_ON_FAIL=1 -> DONE after the E1 check of addr 2 (running 4+6=10 cycles). o_fail_addr=2, o_fail_exp=16'h0000, o_fail_got=16'h0008, o_fail_count=1, o_passed=0.
- Same fault with STOP_ON_FAIL=0 -> runs the full 44 cycles; o_fail_count=3 (E1, E3, E5 reads); first-fail capture as above; o_passed=0.
- Assert i_rst during E2 -> next cycle IDLE with all outputs 0 and no o_wr_en. With i_run still high, restart at E0 addr 0 and pass after 44 cycles.
- After a failing run, drop i_run for 1 cycle -> IDLE with fail regs held. Re-raise i_run with the fault removed -> fail regs cleared on start; o_passed=1.
